ecc_cmd_sequencer: RTL and testbench

- Upstream APB master for ecc_enc_dec.
- Accepts one ECC command per valid/ready handshake and issues the APB register writes for it (DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL).
- Waits for operation_done, then returns data_out and num_of_errors on a valid/ready response port.
- Skips redundant CODEWORD_WIDTH/NOISE writes and times out if operation_done never arrives.

---
 rtl/ecc_pkg.sv | 55 +++++
 rtl/ecc_apb_write_port.sv | 61 ++++++
 rtl/ecc_cmd_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_ecc_cmd_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared types and constants for the ECC command sequencer.
//   op_e         - command opcodes written to CTRL
//   WIDTH_*      - CODEWORD_WIDTH codes
//   *_OFS        - register offsets from the ecc_enc_dec base address
//   seq_state_e  - command FSM states
//   apb_phase_e  - APB write-port phases
//   wr_kind_e    - which register a queued write targets
package ecc_pkg;

  typedef enum logic [1:0] {
    ENCODE       = 2'd0,
    DECODE       = 2'd1,
    FULL_CHANNEL = 2'd2
  } op_e;

  localparam logic [1:0] WIDTH_8  = 2'd0;
  localparam logic [1:0] WIDTH_16 = 2'd1;
  localparam logic [1:0] WIDTH_32 = 2'd2;

  localparam logic [7:0] CTRL_OFS    = 8'h00;
  localparam logic [7:0] DATA_IN_OFS = 8'h04;
  localparam logic [7:0] WIDTH_OFS   = 8'h08;
  localparam logic [7:0] NOISE_OFS   = 8'h0C;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WAIT_DONE,
    RESP
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } apb_phase_e;

  typedef enum logic [1:0] {
    WR_DATA,
    WR_WIDTH,
    WR_NOISE,
    WR_CTRL
  } wr_kind_e;

  function automatic logic [7:0] reg_ofs(input wr_kind_e kind);
    case (kind)
      WR_DATA:  return DATA_IN_OFS;
      WR_WIDTH: return WIDTH_OFS;
      WR_NOISE: return NOISE_OFS;
      default:  return CTRL_OFS;
    endcase
  endfunction

endpackage

// File: rtl/ecc_apb_write_port.sv
// ecc_apb_write_port: runs one APB write (SETUP then ACCESS) per request.
//   clk, reset       - clock, asynchronous active-low reset
//   wr_req           - request a write; accepted when idle or in the ACCESS
//                      cycle of the previous write (back-to-back writes)
//   wr_addr, wr_data - address/data of the requested write
//   wr_done          - one-cycle pulse in the ACCESS cycle
//   PADDR..PWDATA    - APB master outputs; PADDR/PWDATA hold when idle
module ecc_apb_write_port
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_req,
  input  logic [AMBA_ADDR_WIDTH-1:0] wr_addr,
  input  logic [AMBA_WORD-1:0]       wr_data,
  output logic                       wr_done,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA
);

  apb_phase_e phase, phase_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase <= PH_IDLE;
    else        phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_IDLE:   if (wr_req) phase_nxt = PH_SETUP;
      PH_SETUP:  phase_nxt = PH_ACCESS;
      PH_ACCESS: phase_nxt = wr_req ? PH_SETUP : PH_IDLE;
      default:   phase_nxt = PH_IDLE;
    endcase
  end

  // Address/data are loaded as the SETUP cycle begins and held until the
  // next request, so the bus keeps its last value while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (wr_req && (phase != PH_SETUP)) begin
      PADDR  <= wr_addr;
      PWDATA <= wr_data;
    end
  end

  assign PSEL    = (phase != PH_IDLE);
  assign PENABLE = (phase == PH_ACCESS);
  assign PWRITE  = PSEL;
  assign wr_done = PENABLE;

endmodule

// File: rtl/ecc_cmd_sequencer.sv
// ecc_cmd_sequencer: APB master that drives ecc_enc_dec one command at a time.
//   clk, reset                  - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         - command handshake (op, width, data, noise)
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA - APB write bus to the ECC block
//   data_out/operation_done/num_of_errors - ECC result interface
//   rsp_valid/rsp_ready         - response handshake (data, errors, timeout)
// Each command writes DATA_IN, optionally CODEWORD_WIDTH and NOISE (skipped
// when the shadowed value already matches), then CTRL, and waits up to
// TIMEOUT_CYCLES for operation_done.
module ecc_cmd_sequencer
  import ecc_pkg::*;
#(
  parameter int                         AMBA_WORD       = 32,
  parameter int                         AMBA_ADDR_WIDTH = 20,
  parameter logic [AMBA_ADDR_WIDTH-1:0] ECC_BASE        = '0,
  parameter int                         TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [1:0]                 cmd_width,
  input  logic [AMBA_WORD-1:0]       cmd_data,
  input  logic [AMBA_WORD-1:0]       cmd_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic [AMBA_WORD-1:0]       data_out,
  input  logic                       operation_done,
  input  logic [1:0]                 num_of_errors,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [AMBA_WORD-1:0]       rsp_data,
  output logic [1:0]                 rsp_errors,
  output logic                       rsp_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e state, state_nxt;

  logic [1:0]                 op_q;
  logic [1:0]                 width_q;
  logic [AMBA_WORD-1:0]       noise_q;
  logic [2:0]                 pend;        // writes still to issue: {ctrl, noise, width}
  wr_kind_e                   cur_kind;    // register targeted by the write on the bus
  wr_kind_e                   wr_kind;
  logic                       wr_req;
  logic                       wr_done;
  logic [AMBA_ADDR_WIDTH-1:0] wr_addr;
  logic [AMBA_WORD-1:0]       wr_data;
  logic                       width_vld;
  logic [1:0]                 width_shadow;
  logic                       noise_vld;
  logic [AMBA_WORD-1:0]       noise_shadow;
  logic [CNT_W-1:0]           tmo_cnt;
  logic                       tmo_hit;
  logic                       need_width;
  logic                       need_noise;
  logic                       cmd_take;

  function automatic wr_kind_e next_kind(input logic [2:0] p);
    if (p[0])      return WR_WIDTH;
    else if (p[1]) return WR_NOISE;
    else           return WR_CTRL;
  endfunction

  assign cmd_take   = (state == IDLE) && cmd_valid;
  assign need_width = !width_vld || (width_shadow != cmd_width);
  assign need_noise = (cmd_op == FULL_CHANNEL) &&
                      (!noise_vld || (noise_shadow != cmd_noise));
  // The 64th WAIT_DONE cycle sees tmo_cnt == TIMEOUT_CYCLES-1.
  assign tmo_hit    = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign cmd_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);

  // DATA_IN is issued straight from the command inputs in the handshake
  // cycle; everything later comes from the latched command.
  assign wr_addr = ECC_BASE + AMBA_ADDR_WIDTH'(reg_ofs(wr_kind));

  always_comb begin
    case (wr_kind)
      WR_DATA:  wr_data = cmd_data;
      WR_WIDTH: wr_data = AMBA_WORD'(width_q);
      WR_NOISE: wr_data = noise_q;
      default:  wr_data = AMBA_WORD'(op_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_req    = 1'b0;
    wr_kind   = WR_DATA;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = SETUP;
          wr_req    = 1'b1;
          wr_kind   = WR_DATA;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (wr_done) begin
          if (pend != '0) begin
            state_nxt = SETUP;
            wr_req    = 1'b1;
            wr_kind   = next_kind(pend);
          end else begin
            state_nxt = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: if (operation_done || tmo_hit) state_nxt = RESP;
      RESP:      if (rsp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend        <= '0;
      cur_kind    <= WR_DATA;
      width_vld   <= 1'b0;
      noise_vld   <= 1'b0;
      tmo_cnt     <= '0;
      rsp_data    <= '0;
      rsp_errors  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (cmd_take) begin
        pend <= {1'b1, need_noise, need_width};
      end else if ((state == ACCESS) && wr_req) begin
        case (wr_kind)
          WR_WIDTH: pend[0] <= 1'b0;
          WR_NOISE: pend[1] <= 1'b0;
          default:  pend[2] <= 1'b0;
        endcase
      end

      if (wr_req) cur_kind <= wr_kind;

      if (state == ACCESS) begin
        if (cur_kind == WR_WIDTH) width_vld <= 1'b1;
        if (cur_kind == WR_NOISE) noise_vld <= 1'b1;
      end

      if (state == WAIT_DONE)               tmo_cnt <= tmo_cnt + 1'b1;
      else if ((state == RESP) && rsp_ready) tmo_cnt <= '0;

      // A done pulse on the timeout cycle still counts as a completion.
      if (state == WAIT_DONE) begin
        if (operation_done) begin
          rsp_data    <= data_out;
          rsp_errors  <= num_of_errors;
          rsp_timeout <= 1'b0;
        end else if (tmo_hit) begin
          rsp_data    <= '0;
          rsp_errors  <= '0;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_take) begin
      op_q    <= cmd_op;
      width_q <= cmd_width;
      noise_q <= cmd_noise;
    end
    if ((state == ACCESS) && (cur_kind == WR_WIDTH)) width_shadow <= width_q;
    if ((state == ACCESS) && (cur_kind == WR_NOISE)) noise_shadow <= noise_q;
  end

  ecc_apb_write_port #(
    .AMBA_WORD      (AMBA_WORD),
    .AMBA_ADDR_WIDTH(AMBA_ADDR_WIDTH)
  ) u_apb_wr (
    .clk    (clk),
    .reset  (reset),
    .wr_req (wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_done(wr_done),
    .PADDR  (PADDR),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA)
  );

endmodule

// File: tb/tb_ecc_cmd_sequencer.sv
// tb_ecc_cmd_sequencer: directed self-checking bench for ecc_cmd_sequencer.
// Commands are issued one at a time; the APB writes seen on the bus are
// recorded and compared with hand-written expected lists, and response
// latency/fields are compared with hand-computed values.
module tb_ecc_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_width;
  logic [31:0] cmd_data;
  logic [31:0] cmd_noise;
  logic [19:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] data_out;
  logic        operation_done;
  logic [1:0]  num_of_errors;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_errors;
  logic        rsp_timeout;

  int n_checks = 0;
  int n_errors = 0;

  logic [52:0] wr_log[$];
  logic [52:0] exp_q[$];

  ecc_cmd_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_width     (cmd_width),
    .cmd_data      (cmd_data),
    .cmd_noise     (cmd_noise),
    .PADDR         (PADDR),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PWRITE        (PWRITE),
    .PWDATA        (PWDATA),
    .data_out      (data_out),
    .operation_done(operation_done),
    .num_of_errors (num_of_errors),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_errors    (rsp_errors),
    .rsp_timeout   (rsp_timeout)
  );

  always #5 clk = ~clk;

  // Record every completed APB write (ACCESS cycle) as {PWRITE, PADDR, PWDATA}.
  always @(negedge clk) begin
    if (PSEL && PENABLE) wr_log.push_back({PWRITE, PADDR, PWDATA});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_wr(input logic [19:0] addr, input logic [31:0] data);
    exp_q.push_back({1'b1, addr, data});
  endtask

  // Issue one command and follow it to the response handshake.
  // nwr: expected number of APB writes; done_dly: WAIT_DONE cycle (0-based)
  // in which operation_done is pulsed, -1 for never; hold: cycles rsp_ready
  // stays low after rsp_valid is seen.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [1:0] w,
                         input logic [31:0] d, input logic [31:0] nz, input int nwr,
                         input int done_dly, input logic [31:0] dout, input logic [1:0] errs,
                         input int exp_lat, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_rerr, input logic exp_to, input int hold);
    int lat;
    logic got;
    wr_log.delete();
    cmd_op    = op;
    cmd_width = w;
    cmd_data  = d;
    cmd_noise = nz;
    cmd_valid = 1'b1;
    check({tag, "/cmd_ready"}, 64'(cmd_ready), 64'd1);
    lat = 0;
    got = 1'b0;
    while (lat < 200 && !got) begin
      @(posedge clk);
      #1;
      lat++;
      cmd_valid      = 1'b0;
      operation_done = 1'b0;
      data_out       = 32'hFEED_FACE;
      num_of_errors  = 2'b11;
      if (rsp_valid) begin
        got = 1'b1;
      end else if (done_dly >= 0 && lat == 2 * nwr + 1 + done_dly) begin
        operation_done = 1'b1;
        data_out       = dout;
        num_of_errors  = errs;
      end
    end
    operation_done = 1'b0;
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    if (!got) begin
      check({tag, "/rsp_valid_seen"}, 64'(rsp_valid), 64'd1);
      return;
    end
    check({tag, "/rsp_data"}, 64'(rsp_data), 64'(exp_rdata));
    check({tag, "/rsp_errors"}, 64'(rsp_errors), 64'(exp_rerr));
    check({tag, "/rsp_timeout"}, 64'(rsp_timeout), 64'(exp_to));
    check({tag, "/cmd_ready_busy"}, 64'(cmd_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "/hold_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "/hold_data"}, {30'd0, rsp_timeout, rsp_errors, rsp_data},
            {30'd0, exp_to, exp_rerr, exp_rdata});
      check({tag, "/hold_cmd_ready"}, 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "/rsp_valid_cleared"}, 64'(rsp_valid), 64'd0);
    check({tag, "/cmd_ready_back"}, 64'(cmd_ready), 64'd1);
    check({tag, "/n_writes"}, 64'(wr_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
      check($sformatf("%s/write%0d", tag, i), 64'(wr_log[i]), 64'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    reset          = 1'b0;
    cmd_valid      = 1'b0;
    cmd_op         = 2'd0;
    cmd_width      = 2'd0;
    cmd_data       = '0;
    cmd_noise      = '0;
    data_out       = '0;
    operation_done = 1'b0;
    num_of_errors  = 2'd0;
    rsp_ready      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset/cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset/apb_ctl", {61'd0, PSEL, PENABLE, PWRITE}, 64'd0);
    check("reset/apb_bus", {12'd0, PADDR, PWDATA}, 64'd0);
    check("reset/rsp", {29'd0, rsp_valid, rsp_timeout, rsp_errors, rsp_data}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // First encode: width shadow invalid, so 3 writes -> latency 1+6+1.
    expect_wr(20'h04, 32'h0000_00A5);
    expect_wr(20'h08, 32'd2);
    expect_wr(20'h00, 32'd0);
    run_cmd("enc_first", 2'd0, 2'd2, 32'h0000_00A5, 32'h0, 3, 0, 32'h1234_5678, 2'd0,
            8, 32'h1234_5678, 2'd0, 1'b0, 0);

    // Same width: CODEWORD_WIDTH skipped, latency 6.
    expect_wr(20'h04, 32'h0000_005A);
    expect_wr(20'h00, 32'd0);
    run_cmd("enc_same_w", 2'd0, 2'd2, 32'h0000_005A, 32'h0, 2, 0, 32'hCAFE_F00D, 2'd1,
            6, 32'hCAFE_F00D, 2'd1, 1'b0, 0);

    // Full channel, new width and first noise: 4 writes, done 2 cycles late.
    expect_wr(20'h04, 32'h0000_0033);
    expect_wr(20'h08, 32'd0);
    expect_wr(20'h0C, 32'h0000_0001);
    expect_wr(20'h00, 32'd2);
    run_cmd("fc_first", 2'd2, 2'd0, 32'h0000_0033, 32'h0000_0001, 4, 2, 32'hDEAD_BEEF, 2'd2,
            12, 32'hDEAD_BEEF, 2'd2, 1'b0, 0);

    // Same noise and width: only DATA_IN and CTRL; response held 5 cycles.
    expect_wr(20'h04, 32'h0000_0044);
    expect_wr(20'h00, 32'd2);
    run_cmd("fc_same", 2'd2, 2'd0, 32'h0000_0044, 32'h0000_0001, 2, 0, 32'h0BAD_C0DE, 2'd1,
            6, 32'h0BAD_C0DE, 2'd1, 1'b0, 5);

    // No done: 64 WAIT_DONE cycles (5..68), rsp_valid on cycle 69.
    expect_wr(20'h04, 32'h0000_0055);
    expect_wr(20'h00, 32'd1);
    run_cmd("timeout", 2'd1, 2'd0, 32'h0000_0055, 32'h0, 2, -1, 32'h0, 2'd0,
            69, 32'h0, 2'd0, 1'b1, 0);

    // Reserved op: CTRL=3, then times out.
    expect_wr(20'h04, 32'h0000_0066);
    expect_wr(20'h00, 32'd3);
    run_cmd("op3", 2'd3, 2'd0, 32'h0000_0066, 32'h0, 2, -1, 32'h0, 2'd0,
            69, 32'h0, 2'd0, 1'b1, 0);

    // Done on the very cycle the timeout would fire: done wins.
    expect_wr(20'h04, 32'h0000_0077);
    expect_wr(20'h00, 32'd0);
    run_cmd("done_at_tmo", 2'd0, 2'd0, 32'h0000_0077, 32'h0, 2, 63, 32'h7777_0001, 2'd1,
            69, 32'h7777_0001, 2'd1, 1'b0, 0);

    // operation_done while idle is ignored.
    operation_done = 1'b1;
    data_out       = 32'h1111_2222;
    @(posedge clk);
    #1;
    operation_done = 1'b0;
    check("idle_done/cmd_ready", 64'(cmd_ready), 64'd1);
    check("idle_done/rsp_valid", 64'(rsp_valid), 64'd0);

    // Reset during the ACCESS cycle of DATA_IN.
    cmd_op    = 2'd0;
    cmd_width = 2'd0;
    cmd_data  = 32'h0000_0088;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("rst_mid/setup", {43'd0, PSEL, PENABLE, PADDR}, {43'd0, 1'b1, 1'b0, 20'h04});
    @(posedge clk);
    #1;
    check("rst_mid/access", {62'd0, PSEL, PENABLE}, 64'd3);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid/apb_drop", {61'd0, PSEL, PENABLE, PWRITE}, 64'd0);
    check("rst_mid/ready_valid", {62'd0, cmd_ready, rsp_valid}, 64'd2);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_mid/no_rsp", 64'(rsp_valid), 64'd0);
    end

    // Shadows were cleared: CODEWORD_WIDTH is written again.
    expect_wr(20'h04, 32'h0000_0099);
    expect_wr(20'h08, 32'd0);
    expect_wr(20'h00, 32'd0);
    run_cmd("post_rst", 2'd0, 2'd0, 32'h0000_0099, 32'h0, 3, 0, 32'h0000_9999, 2'd0,
            8, 32'h0000_9999, 2'd0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
